// File: rtl/aircraft_agent.sv
// aircraft_agent
// ---------------------------------------------------------------------------
// Aircraft-side endpoint of the BobATC 9-bit message protocol. A start pulse
// from the mission controller issues a takeoff or landing request to the
// tower. The agent then interprets the tower's replies:
//   CLEAR     -> occupy the runway for RUNWAY_TIME cycles, then send DECLARE
//   HOLD      -> wait indefinitely (no timer) for CLEAR / DIVERT / SAY_AGAIN
//   DIVERT    -> give up and return to idle with a diverted pulse
//   SAY_AGAIN -> retransmit the request (also done on reply timeout)
// Once MAX_RETRY retransmissions have been used up, the agent aborts and
// sets the sticky error flag.
//
// Message format: {id[3:0], type[2:0], action[1:0]}; action[1] = direction
// (1 = landing), action[0] = runway.
//
// Optional feature: define AIRCRAFT_EMERGENCY_EN to make ABORT transmit an
// EMERGENCY message {PLANE_ID, 010, dir, 0} before returning to idle.
//
// tx handshake: tx_data is offered while tx_valid is high and is held
// stable until the cycle tx_valid && tx_ready is seen; that cycle is the
// transfer. rx has no back-pressure: rx_data is taken whenever rx_valid=1.
//
// Ports
//   clock      in   single clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   one-cycle pulse: begin a request (ignored while busy)
//   want_land  in   sampled with start: 1 = landing, 0 = takeoff
//   rx_data    in   [8:0] message from tower
//   rx_valid   in   rx_data valid this cycle
//   tx_data    out  [8:0] message to tower
//   tx_valid   out  tx_data pending
//   tx_ready   in   link accepts tx_data this cycle
//   busy       out  high in every state except IDLE
//   on_runway  out  runway occupied by this plane
//   runway_id  out  runway granted by the last CLEAR
//   done       out  one-cycle pulse after DECLARE is accepted
//   diverted   out  one-cycle pulse on DIVERT reply
//   error      out  sticky retry-exhaustion flag, cleared by reset or start
//   state_dbg  out  [2:0] current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module aircraft_agent #(
  parameter logic [3:0] PLANE_ID    = 4'd0,
  parameter int         TIMEOUT     = 255,
  parameter int         MAX_RETRY   = 3,
  parameter int         RUNWAY_TIME = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       want_land,
  input  logic [8:0] rx_data,
  input  logic       rx_valid,
  output logic [8:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       on_runway,
  output logic       runway_id,
  output logic       done,
  output logic       diverted,
  output logic       error,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SEND_REQ   = 3'd1,
    S_WAIT_REPLY = 3'd2,
    S_HOLDING    = 3'd3,
    S_ON_RUNWAY  = 3'd4,
    S_SEND_DECL  = 3'd5,
    S_ABORT      = 3'd6
  } state_t;

  localparam logic [2:0] T_REQUEST   = 3'b000;
  localparam logic [2:0] T_DECLARE   = 3'b001;
  localparam logic [2:0] T_CLEAR     = 3'b100;
  localparam logic [2:0] T_HOLD      = 3'b101;
  localparam logic [2:0] T_SAY_AGAIN = 3'b110;
  localparam logic [2:0] T_DIVERT    = 3'b111;
`ifdef AIRCRAFT_EMERGENCY_EN
  localparam logic [2:0] T_EMERGENCY = 3'b010;
`endif

  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int RW  = $clog2(RUNWAY_TIME + 1);
  localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Counters stop at their "last" value, so none of them can wrap.
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0]  RUN_LAST   = RW'(RUNWAY_TIME - 1);
  localparam logic [RTW-1:0] RETRY_MAX  = RTW'(MAX_RETRY);

  state_t         state, state_n;
  logic           dir, dir_n;
  logic [TW-1:0]  timer, timer_n;
  logic [RW-1:0]  run_cnt, run_cnt_n;
  logic [RTW-1:0] retries, retries_n;
  logic [8:0]     tx_data_n;
  logic           tx_valid_n, busy_n, on_runway_n, runway_id_n;
  logic           done_n, diverted_n, error_n;
  logic           do_retry;

  logic [3:0] rx_id;
  logic [2:0] rx_type;
  logic       rx_match;
  logic       hs;
  logic       unused_rx_dir;

  assign rx_id    = rx_data[8:5];
  assign rx_type  = rx_data[4:2];
  // Only tower-to-plane types (CLEAR..DIVERT, type[2]=1) addressed to us.
  assign rx_match = rx_valid && (rx_id == PLANE_ID) && rx_type[2];
  assign hs       = tx_valid && tx_ready;
  // The direction echoed by the tower is not needed by the aircraft.
  assign unused_rx_dir = rx_data[1];

  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    dir_n       = dir;
    timer_n     = timer;
    run_cnt_n   = run_cnt;
    retries_n   = retries;
    tx_data_n   = tx_data;
    tx_valid_n  = 1'b0;
    on_runway_n = 1'b0;
    runway_id_n = runway_id;
    done_n      = 1'b0;
    diverted_n  = 1'b0;
    error_n     = error;
    do_retry    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_SEND_REQ;
          dir_n      = want_land;
          error_n    = 1'b0;
          retries_n  = '0;
          tx_valid_n = 1'b1;
          tx_data_n  = {PLANE_ID, T_REQUEST, want_land, 1'b0};
        end
      end

      S_SEND_REQ, S_SEND_DECL: begin
        if (hs) begin
          if (state == S_SEND_REQ) begin
            state_n = S_WAIT_REPLY;
            timer_n = '0;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          tx_valid_n = 1'b1;
        end
      end

      S_WAIT_REPLY, S_HOLDING: begin
        // A matching reply wins over a timeout expiring in the same cycle.
        if (rx_match) begin
          unique case (rx_type)
            T_CLEAR: begin
              state_n     = S_ON_RUNWAY;
              runway_id_n = rx_data[0];
              run_cnt_n   = '0;
              on_runway_n = 1'b1;
            end
            T_HOLD: state_n = S_HOLDING;
            T_DIVERT: begin
              state_n    = S_IDLE;
              diverted_n = 1'b1;
            end
            T_SAY_AGAIN: do_retry = 1'b1;
            default: ;
          endcase
        end else if (state == S_WAIT_REPLY) begin
          if (timer == TIMER_LAST) do_retry = 1'b1;
          else                     timer_n  = timer + TW'(1);
        end
      end

      S_ON_RUNWAY: begin
        if (run_cnt == RUN_LAST) begin
          state_n    = S_SEND_DECL;
          tx_valid_n = 1'b1;
          tx_data_n  = {PLANE_ID, T_DECLARE, dir, runway_id};
        end else begin
          run_cnt_n   = run_cnt + RW'(1);
          on_runway_n = 1'b1;
        end
      end

      S_ABORT: begin
`ifdef AIRCRAFT_EMERGENCY_EN
        if (hs) begin
          state_n = S_IDLE;
          error_n = 1'b1;
        end else begin
          tx_valid_n = 1'b1;
        end
`else
        state_n = S_IDLE;
        error_n = 1'b1;
`endif
      end

      default: state_n = S_IDLE;
    endcase

    if (do_retry) begin
      if (retries < RETRY_MAX) begin
        retries_n  = retries + RTW'(1);
        state_n    = S_SEND_REQ;
        tx_valid_n = 1'b1;
        tx_data_n  = {PLANE_ID, T_REQUEST, dir, 1'b0};
      end else begin
        state_n = S_ABORT;
`ifdef AIRCRAFT_EMERGENCY_EN
        tx_valid_n = 1'b1;
        tx_data_n  = {PLANE_ID, T_EMERGENCY, dir, 1'b0};
`endif
      end
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      dir       <= 1'b0;
      timer     <= '0;
      run_cnt   <= '0;
      retries   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      on_runway <= 1'b0;
      runway_id <= 1'b0;
      done      <= 1'b0;
      diverted  <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      timer     <= timer_n;
      run_cnt   <= run_cnt_n;
      retries   <= retries_n;
      tx_data   <= tx_data_n;
      tx_valid  <= tx_valid_n;
      busy      <= busy_n;
      on_runway <= on_runway_n;
      runway_id <= runway_id_n;
      done      <= done_n;
      diverted  <= diverted_n;
      error     <= error_n;
    end
  end

endmodule

// File: tb/tb_aircraft_agent.sv
// Testbench for aircraft_agent (PLANE_ID=5, TIMEOUT=8, MAX_RETRY=2,
// RUNWAY_TIME=4). Directed protocol scenarios followed by randomized
// request/reply conversations. Expected tx words are built from the message
// format {id, type, action} with plain arithmetic and pushed into exp_q; a
// monitor pops one per observed handshake.
module tb_aircraft_agent;

  localparam int PID  = 5;
  localparam int TMO  = 8;
  localparam int MAXR = 2;
  localparam int RUNT = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset, start, want_land, rx_valid, tx_ready;
  logic [8:0] rx_data;
  logic [8:0] tx_data;
  logic tx_valid, busy, on_runway, runway_id, done, diverted, error;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  aircraft_agent #(
    .PLANE_ID(4'd5), .TIMEOUT(TMO), .MAX_RETRY(MAXR), .RUNWAY_TIME(RUNT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .want_land(want_land),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .on_runway(on_runway), .runway_id(runway_id), .done(done),
    .diverted(diverted), .error(error), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] msg(input int id, input int typ, input int act);
    return 9'(id * 32 + typ * 4 + act);
  endfunction

  // Junk the DUT must ignore: foreign id, or our id with a plane-side type.
  function automatic logic [8:0] junk();
    if ($urandom_range(0, 1) == 1)
      return msg((PID + int'($urandom_range(1, 15))) % 16, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)));
    return msg(PID, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endfunction

  always @(negedge clock) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("tx_word", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // The word must be offered right now; it is accepted at the next edge.
  task automatic expect_tx(input string tag, input logic [8:0] w);
    check({tag, "_valid"}, 32'(tx_valid), 32'd1);
    exp_q.push_back(w);
    step();
  endtask

  task automatic send_rx(input logic [8:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 9'($urandom_range(0, 511));
  endtask

  // n cycles of waiting with no tx, plane busy and off the runway; injects
  // one ignorable rx word and maybe a start pulse that must be ignored.
  task automatic quiet(input int n);
    int bad = 0;
    int j = (n > 0) ? int'($urandom_range(0, n - 1)) : 0;
    for (int i = 0; i < n; i++) begin
      if (tx_valid !== 1'b0 || busy !== 1'b1 || on_runway !== 1'b0) bad++;
      if (i == j && $urandom_range(0, 1) == 1) begin
        rx_data  = junk();
        rx_valid = 1'b1;
      end
      start     = ($urandom_range(0, 7) == 0);
      want_land = 1'($urandom_range(0, 1));
      step();
      rx_valid = 1'b0;
      start    = 1'b0;
    end
    check("quiet", 32'(bad), 32'd0);
  endtask

  task automatic start_req(input bit wl);
    check("idle_before_start", 32'(busy), 32'd0);
    start     = 1'b1;
    want_land = wl;
    step();
    start     = 1'b0;
    want_land = 1'($urandom_range(0, 1));
    check("busy_after_start", 32'(busy), 32'd1);
    check("error_cleared", 32'(error), 32'd0);
  endtask

  task automatic check_runway(input bit rw, input bit wl);
    int n = 0;
    check("runway_rise", 32'(on_runway), 32'd1);
    while (on_runway === 1'b1 && n < RUNT + 4) begin
      n++;
      step();
    end
    check("runway_len", 32'(n), 32'(RUNT));
    check("runway_id", 32'(runway_id), 32'(rw));
    expect_tx("decl", msg(PID, 1, wl * 2 + rw));
    check("done_pulse", 32'(done), 32'd1);
    check("done_idle", 32'(busy), 32'd0);
    step();
    check("done_low", 32'(done), 32'd0);
  endtask

  task automatic check_divert();
    check("divert_pulse", 32'(diverted), 32'd1);
    check("divert_idle", 32'(busy), 32'd0);
    check("divert_no_tx", 32'(tx_valid), 32'd0);
    step();
    check("divert_low", 32'(diverted), 32'd0);
  endtask

  // Retransmit while retries remain, otherwise abort with error.
  task automatic after_retry(inout int retries, input bit wl, output bit fin);
    if (retries < MAXR) begin
      retries++;
      expect_tx("retx", msg(PID, 0, wl * 2));
      fin = 1'b0;
    end else begin
`ifdef AIRCRAFT_EMERGENCY_EN
      expect_tx("emerg", msg(PID, 2, wl * 2));
`else
      check("abort_busy", 32'(busy), 32'd1);
      check("abort_no_tx", 32'(tx_valid), 32'd0);
      step();
`endif
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_error", 32'(error), 32'd1);
      fin = 1'b1;
    end
  endtask

  task automatic random_txn();
    bit wl, holding, fin, rw;
    int retries, c, d;
    wl = 1'($urandom_range(0, 1));
    retries = 0; holding = 1'b0; fin = 1'b0;
    start_req(wl);
    expect_tx("req", msg(PID, 0, wl * 2));
    while (!fin) begin
      c = holding ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
      if (c == 3) begin
        quiet(TMO);
        after_retry(retries, wl, fin);
      end else begin
        // d up to TMO-1 includes a reply in the very cycle the timer expires.
        d = holding ? 0 : int'($urandom_range(0, TMO - 1));
        quiet(d);
        case (c)
          0: begin
            rw = 1'($urandom_range(0, 1));
            send_rx(msg(PID, 4, int'($urandom_range(0, 1)) * 2 + rw));
            check_runway(rw, wl);
            fin = 1'b1;
          end
          1: begin
            send_rx(msg(PID, 7, int'($urandom_range(0, 3))));
            check_divert();
            fin = 1'b1;
          end
          2: begin
            send_rx(msg(PID, 6, int'($urandom_range(0, 3))));
            holding = 1'b0;
            after_retry(retries, wl, fin);
          end
          default: begin
            send_rx(msg(PID, 5, int'($urandom_range(0, 3))));
            holding = 1'b1;
            quiet(int'($urandom_range(TMO + 1, 3 * TMO)));
          end
        endcase
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bit fin;
    int retries;
    int bad;
    reset = 1'b1; start = 1'b0; want_land = 1'b0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1;
    repeat (3) step();
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_on_runway", 32'(on_runway), 32'd0);
    check("rst_runway_id", 32'(runway_id), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diverted", 32'(diverted), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    step();

    // Landing: request, CLEAR runway 1, declare.
    start_req(1'b1);
    check("land_req_word", 32'(tx_data), 32'h0A2);
    expect_tx("land_req", msg(PID, 0, 2));
    quiet(3);
    send_rx(9'h0B3);
    check_runway(1'b1, 1'b1);

    // Takeoff: HOLD suppresses timeout, SAY_AGAIN retransmits, DIVERT ends.
    start_req(1'b0);
    check("to_req_word", 32'(tx_data), 32'h0A0);
    expect_tx("to_req", msg(PID, 0, 0));
    send_rx(9'h0B4);
    quiet(50);
    send_rx(9'h0B8);
    retries = 0;
    after_retry(retries, 1'b0, fin);
    quiet(2);
    send_rx(9'h0BC);
    check_divert();

    // Silence: three requests TIMEOUT idle cycles apart, then abort.
    start_req(1'b0);
    expect_tx("sil_req", msg(PID, 0, 0));
    retries = 0;
    fin = 1'b0;
    while (!fin) begin
      quiet(TMO);
      after_retry(retries, 1'b0, fin);
    end
    // New start clears error; id-6 CLEAR is ignored, our CLEAR is taken.
    start_req(1'b0);
    expect_tx("clr_req", msg(PID, 0, 0));
    send_rx(9'h0D3);
    check("foreign_ignored", 32'(on_runway), 32'd0);
    quiet(2);
    send_rx(9'h0B3);
    check_runway(1'b1, 1'b0);

    // Back-pressure holds the request, then reset mid-runway kills declare.
    start_req(1'b1);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(tx_valid), 32'd1);
      check("bp_data", 32'(tx_data), 32'h0A2);
      step();
    end
    tx_ready = 1'b1;
    expect_tx("bp_req", msg(PID, 0, 2));
    quiet(1);
    send_rx(9'h0B2);
    check("mid_on_runway", 32'(on_runway), 32'd1);
    step();
    reset = 1'b1;
    step();
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_on_runway", 32'(on_runway), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_runway_id", 32'(runway_id), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < RUNT + 4; i++) begin
      if (tx_valid !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    check("no_declare_after_reset", 32'(bad), 32'd0);

    // Randomized conversations.
    for (int t = 0; t < 40; t++) begin
      random_txn();
      repeat ($urandom_range(0, 3)) step();
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
